// File: rtl/twiddle_type_seq.sv
// Trivial-twiddle bypass sequencer for a radix-2 DIF FFT. It emits one descriptor per butterfly
// (stage, butterfly, twiddle exponent, bypass code). Define TWIDDLE_CONJ_EN to add the INV (conjugate twiddle) port.
module twiddle_type_seq #(
  parameter int LOG2N = 6
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       START,
  input  logic                       READY,
`ifdef TWIDDLE_CONJ_EN
  input  logic                       INV,
`endif
  output logic                       VALID,
  output logic [$clog2(LOG2N)-1:0]   STAGE,
  output logic [LOG2N-2:0]           BFLY,
  output logic [LOG2N-2:0]           TWIDX,
  output logic                       TRIVIAL,
  output logic [2:0]                 TYPESEL,
  output logic                       LAST,
  output logic                       BUSY,
  output logic                       DONE
);
  localparam int SW = $clog2(LOG2N);
  localparam int BW = LOG2N - 1;
  localparam logic [BW-1:0] QTR = BW'(1 << (LOG2N - 2));

  typedef enum logic [1:0] {IDLE, RUN, DONE_ST} state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   s, s_nxt;
  logic [BW-1:0]   b, b_nxt;
  logic            run, is_last;
  logic [BW-1:0]   mask, k;
  logic            inv_q;

  assign run     = (state == RUN);
  assign is_last = (s == SW'(LOG2N - 1)) && (b == {BW{1'b1}});

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      s     <= '0;
      b     <= '0;
    end else begin
      state <= state_nxt;
      s     <= s_nxt;
      b     <= b_nxt;
    end
  end

`ifdef TWIDDLE_CONJ_EN
  // Direction is latched with START so it cannot change partway through a transform.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                         inv_q <= 1'b0;
    else if (state == IDLE && START) inv_q <= INV;
  end
`else
  assign inv_q = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    s_nxt     = s;
    b_nxt     = b;
    case (state)
      IDLE: if (START) begin
        state_nxt = RUN;
        s_nxt     = '0;
        b_nxt     = '0;
      end
      RUN: if (READY) begin
        if (is_last) begin
          state_nxt = DONE_ST;
          s_nxt     = '0;
          b_nxt     = '0;
        end else if (b == {BW{1'b1}}) begin
          b_nxt = '0;
          s_nxt = s + SW'(1);
        end else begin
          b_nxt = b + BW'(1);
        end
      end
      DONE_ST: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // k = (b mod 2^(LOG2N-1-s)) << s. The modulus keeps the low BW-s bits of b.
  assign mask = {BW{1'b1}} >> s;
  assign k    = run ? ((b & mask) << s) : '0;

  assign VALID   = run;
  assign BUSY    = run;
  assign DONE    = (state == DONE_ST);
  assign STAGE   = run ? s : '0;
  assign BFLY    = run ? b : '0;
  assign TWIDX   = k;
  assign LAST    = run & is_last;
  assign TRIVIAL = run & ((k == '0) | (k == QTR));
  // W = -j swaps re/im and negates imag; the conjugate (+j) negates real instead.
  assign TYPESEL = (run && k == QTR) ? (inv_q ? 3'b110 : 3'b101) : 3'b000;
endmodule
